// File: rtl/reg_memory_bank.sv
// Synchronous word memory built from D-type storage words: one write port, one
// registered read port with true/complement outputs, and a sequential clear engine.
module reg_memory_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  D,
    input  logic              RE,
    input  logic [ADDR_W-1:0] RADDR,
    input  logic              CLR,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  NQ,
    output logic              RVALID,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One extra bit so out-of-range addresses compare correctly when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              waddr_ok;
    logic              raddr_ok;
    logic [WIDTH-1:0]  rd_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    assign waddr_ok = ({1'b0, WADDR} < DEPTH_X);
    assign raddr_ok = ({1'b0, RADDR} < DEPTH_X);

    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem[RADDR];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        rvalid_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = WADDR;
        mem_wdata = D;

        unique case (state_q)
            IDLE: begin
                if (CLR) begin
                    // A sweep request swallows any write or read issued alongside it.
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    mem_we = WE && waddr_ok;
                    if (RE) begin
                        rvalid_d = 1'b1;
                        if (!raddr_ok) begin
                            q_d = '0;
                        end else if (WE && (WADDR == RADDR)) begin
                            q_d = D;
                        end else begin
                            q_d = rd_word;
                        end
                    end
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset leaves the array untouched, including the word a sweep was about to clear.
        if (RST) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_out_bit
            assign Q[gi]  = q_q[gi];
            assign NQ[gi] = ~q_q[gi];
        end
    endgenerate

    assign RVALID = rvalid_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule
